// File: rtl/c64_bus_pkg.sv
// Shared constants for the C64 bus responder: decode addresses, CIA timer offsets, CRA bits.
package c64_bus_pkg;

    localparam logic [15:0] ADDR_DDR     = 16'h0000;
    localparam logic [15:0] ADDR_PORT    = 16'h0001;
    localparam logic [15:0] IO_CIA1_BASE = 16'hDC00;

    // Timer register offsets within the 16-byte mirrored CIA window
    localparam logic [3:0] TA_LO = 4'h4;
    localparam logic [3:0] TA_HI = 4'h5;
    localparam logic [3:0] ICR   = 4'hD;
    localparam logic [3:0] CRA   = 4'hE;

    // CRA bit indices
    localparam int unsigned CRA_START   = 0;
    localparam int unsigned CRA_ONESHOT = 3;
    localparam int unsigned CRA_LOAD    = 4;

    localparam logic [7:0] PORT_RESET = 8'h37;

    // Pins configured as inputs float high, so an unset DDR bit reads as 1
    function automatic logic [2:0] eff_bank(input logic [7:0] port, input logic [7:0] ddr);
        return (port[2:0] & ddr[2:0]) | ~ddr[2:0];
    endfunction

endpackage

// File: rtl/c64_timer_a.sv
// CIA-lite timer A: 16-bit down counter with latch, control register and masked IRQ.
module c64_timer_a
    import c64_bus_pkg::*;
#(
    parameter logic [15:0] TMR_RESET = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic       we,
    input  logic [3:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq_n
);

    logic [15:0] r_latch;
    logic [15:0] r_counter;
    logic        r_start;
    logic        r_oneshot;
    logic        r_mask;
    logic        r_flag;
    logic        r_irq_n;

    logic w_wr;
    logic w_rd;
    logic w_underflow;
    logic w_irq_active;

    assign w_wr         = sel & we;
    assign w_rd         = sel & ~we;
    assign w_underflow  = r_start & (r_counter == 16'd0);
    assign w_irq_active = r_flag & r_mask;
    assign irq_n        = r_irq_n;

    // Register read mux; force-load is a strobe and never reads back
    always_comb begin
        rdata = 8'h00;
        case (reg_addr)
            TA_LO:   rdata = r_counter[7:0];
            TA_HI:   rdata = r_counter[15:8];
            ICR:     rdata = {w_irq_active, 6'b000000, r_flag};
            CRA:     rdata = {4'b0000, r_oneshot, 2'b00, r_start};
            default: rdata = 8'h00;
        endcase
    end

    // Counting first, then bus writes; later assignments win (force-load beats decrement)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_latch   <= TMR_RESET;
            r_counter <= TMR_RESET;
            r_start   <= 1'b0;
            r_oneshot <= 1'b0;
            r_mask    <= 1'b0;
            r_flag    <= 1'b0;
            r_irq_n   <= 1'b1;
        end else begin
            if (r_start) begin
                r_counter <= w_underflow ? r_latch : r_counter - 16'd1;
            end
            if (w_underflow && r_oneshot) begin
                r_start <= 1'b0;
            end
            // Underflow set wins over the clear-on-read of ICR
            if (w_underflow) begin
                r_flag <= 1'b1;
            end else if (w_rd && (reg_addr == ICR)) begin
                r_flag <= 1'b0;
            end
            r_irq_n <= ~w_irq_active;

            if (w_wr) begin
                case (reg_addr)
                    TA_LO: r_latch[7:0] <= wdata;
                    TA_HI: begin
                        r_latch[15:8] <= wdata;
                        if (!r_start) begin
                            r_counter <= {wdata, r_latch[7:0]};
                        end
                    end
                    ICR: begin
                        if (wdata[7]) begin
                            r_mask <= r_mask | wdata[0];
                        end else begin
                            r_mask <= r_mask & ~wdata[0];
                        end
                    end
                    CRA: begin
                        r_start   <= wdata[CRA_START];
                        r_oneshot <= wdata[CRA_ONESHOT];
                        if (wdata[CRA_LOAD]) begin
                            r_counter <= r_latch;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/c64_bus_responder.sv
// Far-end bus responder for the 6502 core: system RAM, 6510 processor port, CIA timer A.
module c64_bus_responder
    import c64_bus_pkg::*;
#(
    parameter int unsigned RAM_AW    = 16,
    parameter logic [15:0] TMR_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ab,
    input  logic        we,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    output logic        irq_n,
    output logic [2:0]  bank
);

    localparam int unsigned RamDepth = 2 ** RAM_AW;

    logic [7:0] r_ram [RamDepth];
    logic [7:0] r_ddr;
    logic [7:0] r_port;
    logic [7:0] r_cpu_di;

    logic [RAM_AW-1:0] w_ram_addr;
    logic [2:0]        w_bank;
    logic              w_io_en;
    logic              w_sel_ddr;
    logic              w_sel_port;
    logic              w_sel_io;
    logic [7:0]        w_tmr_rdata;
    logic [7:0]        w_rdata;

    assign w_ram_addr = ab[RAM_AW-1:0];
    assign w_bank     = eff_bank(r_port, r_ddr);
    assign w_io_en    = w_bank[2] & (w_bank[1] | w_bank[0]);
    assign w_sel_ddr  = (ab == ADDR_DDR);
    assign w_sel_port = (ab == ADDR_PORT);
    assign w_sel_io   = w_io_en & (ab[15:8] == IO_CIA1_BASE[15:8]);
    assign bank       = w_bank;
    assign cpu_di     = r_cpu_di;

    c64_timer_a #(
        .TMR_RESET (TMR_RESET)
    ) u_timer_a (
        .clk      (clk),
        .reset    (reset),
        .sel      (w_sel_io),
        .we       (we),
        .reg_addr (ab[3:0]),
        .wdata    (cpu_do),
        .rdata    (w_tmr_rdata),
        .irq_n    (irq_n)
    );

    // Read data decode in priority order: DDR, PORT, I/O window, RAM
    always_comb begin
        w_rdata = r_ram[w_ram_addr];
        if (w_sel_ddr) begin
            w_rdata = r_ddr;
        end else if (w_sel_port) begin
            w_rdata = {r_port[7:3], w_bank};
        end else if (w_sel_io) begin
            w_rdata = w_tmr_rdata;
        end
    end

    // RAM has no reset; $0000/$0001 writes fall through to RAM, the I/O window does not
    always_ff @(posedge clk) begin
        if (we && !w_sel_io) begin
            r_ram[w_ram_addr] <= cpu_do;
        end
    end

    // Processor port registers and the registered read path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ddr    <= 8'h00;
            r_port   <= PORT_RESET;
            r_cpu_di <= 8'h00;
        end else if (we) begin
            if (w_sel_ddr) begin
                r_ddr <= cpu_do;
            end else if (w_sel_port) begin
                r_port <= cpu_do;
            end
        end else begin
            r_cpu_di <= w_rdata;
        end
    end

endmodule

// File: tb/tb_c64_bus_responder.sv
// Directed + randomized bench for c64_bus_responder against a cycle-level behavioural model.
module tb_c64_bus_responder;

    logic        clk;
    logic        reset;
    logic [15:0] ab;
    logic        we;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        irq_n;
    logic [2:0]  bank;

    int n_cmp;
    int n_err;

    // Reference model state
    logic [7:0]  m_mem [0:65535];
    bit          m_vld [0:65535];
    logic [7:0]  m_ddr;
    logic [7:0]  m_port;
    logic [15:0] m_latch;
    logic [15:0] m_cnt;
    bit          m_run;
    bit          m_one;
    bit          m_mask;
    bit          m_flag;
    bit          m_irq_n;
    logic [7:0]  m_di;
    bit          m_di_vld;

    c64_bus_responder dut (
        .clk    (clk),
        .reset  (reset),
        .ab     (ab),
        .we     (we),
        .cpu_do (cpu_do),
        .cpu_di (cpu_di),
        .irq_n  (irq_n),
        .bank   (bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] mbank();
        logic [2:0] b;
        for (int i = 0; i < 3; i++) b[i] = m_ddr[i] ? m_port[i] : 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        m_ddr = 8'h00; m_port = 8'h37;
        m_latch = 16'hFFFF; m_cnt = 16'hFFFF;
        m_run = 0; m_one = 0; m_mask = 0; m_flag = 0; m_irq_n = 1;
        m_di = 8'h00; m_di_vld = 1;
    endtask

    // One bus cycle of the model: read value from pre-edge state, then next state
    task automatic model(input logic [15:0] a, input logic w, input logic [7:0] d);
        logic [2:0]  b;
        bit          in_io;
        int          off;
        bit          uf;
        logic [7:0]  rv;
        bit          rv_ok;
        logic [15:0] ncnt;
        bit          nrun;
        bit          nflag;
        b     = mbank();
        in_io = (b >= 3'd5) && (a >= 16'hDC00) && (a <= 16'hDCFF);
        off   = int'(a) % 16;
        uf    = m_run && (m_cnt == 0);
        rv_ok = 1;
        if (a == 16'h0000) rv = m_ddr;
        else if (a == 16'h0001) rv = {m_port[7:3], b};
        else if (in_io) begin
            case (off)
                4:       rv = m_cnt[7:0];
                5:       rv = m_cnt[15:8];
                13:      rv = {m_flag && m_mask, 6'd0, m_flag};
                14:      rv = {4'd0, m_one, 2'd0, m_run};
                default: rv = 8'h00;
            endcase
        end else begin
            rv = m_mem[a]; rv_ok = m_vld[a];
        end
        m_irq_n = !(m_flag && m_mask);
        ncnt  = !m_run ? m_cnt : (uf ? m_latch : m_cnt - 16'd1);
        nrun  = m_run && !(uf && m_one);
        nflag = uf ? 1'b1 : ((!w && in_io && off == 13) ? 1'b0 : m_flag);
        if (w) begin
            if (!in_io) begin m_mem[a] = d; m_vld[a] = 1; end
            if (a == 16'h0000) m_ddr = d;
            else if (a == 16'h0001) m_port = d;
            else if (in_io) begin
                case (off)
                    4: m_latch[7:0] = d;
                    5: begin
                        m_latch[15:8] = d;
                        if (!m_run) ncnt = {d, m_latch[7:0]};
                    end
                    13: m_mask = d[7] ? (m_mask || d[0]) : (m_mask && !d[0]);
                    14: begin
                        nrun = d[0]; m_one = d[3];
                        if (d[4]) ncnt = m_latch;
                    end
                    default: ;
                endcase
            end
        end else begin
            m_di = rv; m_di_vld = rv_ok;
        end
        m_cnt = ncnt; m_run = nrun; m_flag = nflag;
    endtask

    task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
        ab = a; we = w; cpu_do = d;
        model(a, w, d);
        @(posedge clk); #1;
        if (m_di_vld) chk("cpu_di", cpu_di, m_di);
        chk("irq_n", {7'd0, irq_n}, {7'd0, m_irq_n});
        chk("bank", {5'd0, bank}, {5'd0, mbank()});
    endtask

    task automatic rd(input logic [15:0] a);
        bus(a, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, 1'b1, d);
    endtask

    initial begin
        logic [15:0] pool [8];
        logic [15:0] a;
        int          r;
        n_cmp = 0; n_err = 0;
        pool = '{16'h1234, 16'h0002, 16'h2000, 16'hFFFF, 16'hDC04, 16'h00FF, 16'hA000, 16'hDD00};
        reset = 1'b0; ab = 16'h0000; we = 1'b0; cpu_do = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_di", cpu_di, 8'h00);
        chk("rst_irq_n", {7'd0, irq_n}, 8'h01);
        chk("rst_bank", {5'd0, bank}, 8'h07);
        reset = 1'b1;

        // RAM write/read with one-cycle latency; write cycle holds cpu_di
        wr(16'h1234, 8'hA5);
        chk("write_hold", cpu_di, 8'h00);
        rd(16'h1234);
        chk("ram_rd", cpu_di, 8'hA5);

        // Bank out the I/O window, then restore it
        wr(16'h0000, 8'h07);
        wr(16'h0001, 8'h30);
        chk("bank_off", {5'd0, bank}, 8'h00);
        wr(16'hDC04, 8'h5A);
        rd(16'hDC04);
        chk("io_off_ram", cpu_di, 8'h5A);
        wr(16'h0001, 8'h37);
        rd(16'hDC04);
        chk("io_on_cnt", cpu_di, 8'hFF);
        chk("ram_0001", dut.r_ram[1], 8'h37);

        // Latch 3 with timer stopped loads counter; then run
        wr(16'hDC04, 8'h03);
        wr(16'hDC05, 8'h00);
        rd(16'hDC04);
        chk("cnt_lo_ld", cpu_di, 8'h03);
        wr(16'hDC0E, 8'h01);
        repeat (9) rd(16'hDC14);
        wr(16'hDC0D, 8'h81);
        rd(16'h1234);
        rd(16'h1234);
        chk("irq_asserted", {7'd0, irq_n}, 8'h00);
        wr(16'hDC0E, 8'h00);
        rd(16'hDC0D);
        chk("icr_rd", cpu_di, 8'h81);
        rd(16'h1234);
        chk("irq_released", {7'd0, irq_n}, 8'h01);

        // One-shot: single underflow, start clears, counter reloads and holds
        wr(16'hDC04, 8'h02);
        wr(16'hDC05, 8'h00);
        wr(16'hDC0E, 8'h09);
        repeat (8) rd(16'hDC04);
        rd(16'hDC0E);
        chk("oneshot_cra", cpu_di, 8'h08);
        rd(16'hDC04);
        chk("oneshot_hold", cpu_di, 8'h02);
        rd(16'hDC0D);
        chk("oneshot_flag", cpu_di, 8'h81);
        rd(16'hDC0D);
        chk("oneshot_once", cpu_di, 8'h00);

        // Force-load coinciding with underflow
        wr(16'hDC04, 8'h03);
        wr(16'hDC0E, 8'h01);
        rd(16'h1234);
        rd(16'h1234);
        wr(16'hDC0E, 8'h11);
        rd(16'hDC04);
        chk("fload_cnt", cpu_di, 8'h03);
        rd(16'hDC0D);
        chk("fload_flag", cpu_di, 8'h81);
        rd(16'h1234);
        rd(16'h1234);

        // Asynchronous reset mid-count
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_cpu_di", cpu_di, 8'h00);
        chk("mid_rst_irq_n", {7'd0, irq_n}, 8'h01);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        rd(16'hDC04);
        chk("mid_rst_cnt_lo", cpu_di, 8'hFF);
        rd(16'hDC05);
        chk("mid_rst_cnt_hi", cpu_di, 8'hFF);
        rd(16'h1234);
        chk("ram_kept", cpu_di, 8'hA5);

        // Randomized traffic, small latches so underflows actually happen
        wr(16'hDC0D, 8'h81);
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) a = 16'h0000;
            else if (r == 1) a = 16'h0001;
            else if (r < 9) begin
                case ($urandom_range(0, 4))
                    0: a = 16'hDC04;
                    1: a = 16'hDC05;
                    2: a = 16'hDC0D;
                    3: a = 16'hDC0E;
                    default: a = {8'hDC, 8'($urandom)};
                endcase
            end else a = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) < 3) begin
                if (a == 16'hDC05) wr(a, 8'($urandom_range(0, 1)));
                else if (a == 16'h0000) wr(a, 8'($urandom) & 8'hF8 | 8'h07 & 8'($urandom));
                else wr(a, 8'($urandom));
            end else begin
                rd(a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
